// File: rtl/mdu_serial.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, followed by one sign/special-case fix cycle.
module mdu_serial #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q,  state_d;
    logic [CW-1:0]       cnt_q,    cnt_d;
    logic [2:0]          op_q,     op_d;
    logic                a_neg_q,  a_neg_d;
    logic                b_neg_q,  b_neg_d;
    logic [XLEN-1:0]     a_mag_q,  a_mag_d;
    logic [XLEN-1:0]     b_mag_q,  b_mag_d;
    logic [2*XLEN-1:0]   prod_q,   prod_d;
    logic [XLEN:0]       rem_q,    rem_d;
    logic [XLEN-1:0]     quo_q,    quo_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                valid_q,  valid_d;

    logic                a_signed_s, b_signed_s;
    logic                a_in_neg_s, b_in_neg_s;
    logic [XLEN-1:0]     a_in_mag_s, b_in_mag_s;
    logic [XLEN:0]       mul_sum_s;
    logic [XLEN:0]       div_shift_s, div_diff_s;
    logic [2*XLEN-1:0]   prod_fix_s;
    logic [XLEN-1:0]     quo_fix_s, rem_fix_s, a_orig_s;
    logic                b_zero_s;
    logic [XLEN-1:0]     fix_result_s;

    // Operand signedness of the incoming request.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (op_i)
            OP_MULH, OP_DIV, OP_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            OP_MULHSU: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
    end

    assign a_in_neg_s = a_signed_s & a_i[XLEN-1];
    assign b_in_neg_s = b_signed_s & b_i[XLEN-1];
    assign a_in_mag_s = a_in_neg_s ? ({XLEN{1'b0}} - a_i) : a_i;
    assign b_in_mag_s = b_in_neg_s ? ({XLEN{1'b0}} - b_i) : b_i;

    // Multiplier: upper half accumulates, lower half shifts the multiplier out LSB first.
    assign mul_sum_s   = {1'b0, prod_q[2*XLEN-1:XLEN]}
                       + (prod_q[0] ? {1'b0, a_mag_q} : {(XLEN+1){1'b0}});
    // Divider: dividend bits leave quo_q MSB first while quotient bits enter at the LSB.
    assign div_shift_s = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    assign div_diff_s  = div_shift_s - {1'b0, b_mag_q};

    assign prod_fix_s = (a_neg_q ^ b_neg_q) ? ({(2*XLEN){1'b0}} - prod_q) : prod_q;
    assign quo_fix_s  = (a_neg_q ^ b_neg_q) ? ({XLEN{1'b0}} - quo_q) : quo_q;
    assign rem_fix_s  = a_neg_q ? ({XLEN{1'b0}} - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
    assign a_orig_s   = a_neg_q ? ({XLEN{1'b0}} - a_mag_q) : a_mag_q;
    assign b_zero_s   = (b_mag_q == {XLEN{1'b0}});

    // Final result selection; signed overflow falls out of the magnitude path naturally.
    always_comb begin
        fix_result_s = {XLEN{1'b0}};
        case (op_q)
            OP_MUL:                       fix_result_s = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result_s = prod_fix_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result_s = b_zero_s ? {XLEN{1'b1}} : quo_fix_s;
            OP_REM, OP_REMU:              fix_result_s = b_zero_s ? a_orig_s : rem_fix_s;
            default:                      fix_result_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i && !kill_i) begin
                    op_d    = op_i;
                    a_neg_d = a_in_neg_s;
                    b_neg_d = b_in_neg_s;
                    a_mag_d = a_in_mag_s;
                    b_mag_d = b_in_mag_s;
                    prod_d  = {{XLEN{1'b0}}, b_in_mag_s};
                    rem_d   = {(XLEN+1){1'b0}};
                    quo_d   = a_in_mag_s;
                    cnt_d   = {CW{1'b0}};
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d = {mul_sum_s, prod_q[XLEN-1:1]};
                    if (!div_diff_s[XLEN]) begin
                        rem_d = div_diff_s;
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift_s;
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
            end
            S_FIX: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_result_s;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            op_q     <= 3'd0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            a_mag_q  <= {XLEN{1'b0}};
            b_mag_q  <= {XLEN{1'b0}};
            prod_q   <= {(2*XLEN){1'b0}};
            rem_q    <= {(XLEN+1){1'b0}};
            quo_q    <= {XLEN{1'b0}};
            result_q <= {XLEN{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_mdu_serial.sv
// Bench for mdu_serial: arithmetic reference model plus latency model checked every
// cycle, and directed RV32M vectors with hand-computed results.
module tb_mdu_serial;

    logic        clk;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        kill_i;
    logic        valid_o;
    logic [31:0] result_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    mdu_serial #(.XLEN(32), .ITER(32)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .kill_i   (kill_i),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RV32M semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ia, ib;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'd0, b});
        ia  = int'(a);
        ib  = int'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0:    begin p = sa * sb; return p[31:0]; end
            3'd1:    begin p = sa * sb; return p[63:32]; end
            3'd2:    begin p = sa * ub; return p[63:32]; end
            3'd3:    begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4:    return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
            3'd5:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Timing model: an accepted request is busy for cycles 1..34, result visible from 34.
    bit          m_busy = 1'b0;
    int          m_age = 0;
    logic [31:0] m_pend = 32'd0;
    logic [31:0] m_result = 32'd0;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_busy   <= 1'b0;
            m_age    <= 0;
            m_result <= 32'd0;
        end else if (!m_busy) begin
            if (valid_i && !kill_i) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_pend <= ref_model(op_i, a_i, b_i);
            end
        end else if (m_age <= 33 && kill_i) begin
            m_busy <= 1'b0;
        end else if (m_age == 34) begin
            m_busy <= 1'b0;
        end else begin
            if (m_age == 33) m_result <= m_pend;
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        chk("ready_o", {31'd0, ready_o}, {31'd0, !m_busy});
        chk("valid_o", {31'd0, valid_o}, {31'd0, (m_busy && m_age == 34)});
        chk("result_o", result_o, m_result);
    end

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int kill_cyc);
        int t0, c, seen_cyc;
        bit seen, exp_valid;
        @(negedge clk);
        op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
        t0 = cyc;
        seen = 1'b0;
        seen_cyc = -1;
        for (int k = 0; k < 41; k++) begin
            @(negedge clk);
            c = cyc - t0;
            if (c == 1) valid_i = 1'b0;
            if (valid_o && !seen) begin
                seen = 1'b1;
                seen_cyc = c;
            end
            kill_i = (c == kill_cyc);
        end
        kill_i = 1'b0;
        exp_valid = !(kill_cyc >= 1 && kill_cyc <= 33);
        chk({name, " valid_seen"}, {31'd0, seen}, {31'd0, exp_valid});
        if (exp_valid) chk({name, " latency"}, seen_cyc, 32'd34);
        chk({name, " result"}, result_o, exp);
    endtask

    initial begin
        int t0, c, nv, v1, v2;
        rst_ni = 1'b1; valid_i = 1'b0; kill_i = 1'b0;
        op_i = 3'd0; a_i = 32'd0; b_i = 32'd0;
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset ready_o", {31'd0, ready_o}, 32'd1);
        chk("reset valid_o", {31'd0, valid_o}, 32'd0);
        chk("reset result_o", result_o, 32'd0);
        #2 rst_ni = 1'b1;

        run_op("MUL 7*-3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, -1);
        run_op("MULH",         3'd1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, -1);
        run_op("MULHSU",       3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, -1);
        run_op("MULHU",        3'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'h7FFF_FFFF, -1);
        run_op("DIV -7/2",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, -1);
        run_op("REM -7%2",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, -1);
        run_op("DIVU",         3'd5, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, -1);
        run_op("REMU",         3'd7, 32'hFFFF_FFF9,  32'd2,         32'h0000_0001, -1);
        run_op("DIV by 0",     3'd4, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF, -1);
        run_op("DIVU by 0",    3'd5, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF, -1);
        run_op("REM by 0",     3'd6, 32'h1234_5678,  32'd0,         32'h1234_5678, -1);
        run_op("REMU by 0",    3'd7, 32'h1234_5678,  32'd0,         32'h1234_5678, -1);
        run_op("DIV ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, -1);
        run_op("DIV 100/-7",   3'd4, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, -1);
        run_op("REM ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, -1);
        run_op("REM 100%-7",   3'd6, 32'd100,        32'hFFFF_FFF9, 32'h0000_0002, -1);
        // Aborted in CALC: result stays at the previous value.
        run_op("kill CALC",    3'd0, 32'd3,          32'd5,         32'h0000_0002, 10);
        run_op("kill FIX",     3'd0, 32'd3,          32'd5,         32'h0000_0002, 33);
        run_op("kill DONE",    3'd0, 32'd3,          32'd5,         32'h0000_000F, 34);

        // Kill takes priority over a request in IDLE.
        @(negedge clk);
        op_i = 3'd0; a_i = 32'd9; b_i = 32'd9; valid_i = 1'b1; kill_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; kill_i = 1'b0;
        chk("idle kill ready_o", {31'd0, ready_o}, 32'd1);
        repeat (40) @(negedge clk);
        chk("idle kill result", result_o, 32'h0000_000F);

        // Asynchronous reset in cycle 20 of an operation.
        @(negedge clk);
        op_i = 3'd0; a_i = 32'd7; b_i = 32'hFFFF_FFFD; valid_i = 1'b1;
        t0 = cyc;
        @(negedge clk);
        valid_i = 1'b0;
        while (cyc - t0 < 20) @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        chk("async rst ready_o", {31'd0, ready_o}, 32'd1);
        chk("async rst valid_o", {31'd0, valid_o}, 32'd0);
        chk("async rst result_o", result_o, 32'd0);
        @(negedge clk);
        #2 rst_ni = 1'b1;
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_o) nv++;
        end
        chk("async rst no valid", nv, 32'd0);

        // valid_i held high: accepts in cycles 0 and 35, operand wiggle in CALC ignored.
        @(negedge clk);
        op_i = 3'd0; a_i = 32'd7; b_i = 32'hFFFF_FFFD; valid_i = 1'b1;
        t0 = cyc;
        nv = 0; v1 = -1; v2 = -1;
        for (int k = 0; k < 76; k++) begin
            @(negedge clk);
            c = cyc - t0;
            if (c == 10) a_i = 32'd100;
            if (c == 20) a_i = 32'd7;
            if (c == 36) valid_i = 1'b0;
            if (valid_o) begin
                nv++;
                if (nv == 1) v1 = c;
                if (nv == 2) v2 = c;
            end
        end
        chk("b2b valid count", nv, 32'd2);
        chk("b2b first valid", v1, 32'd34);
        chk("b2b second valid", v2, 32'd69);
        chk("b2b result", result_o, 32'hFFFF_FFEB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_serial.md
Name: mdu_serial

Overview:
- Multi-cycle RV32M multiply/divide unit.
- Sits beside the combinational ALU in the execute stage and takes the same 32-bit operand pair.
- Returns one 32-bit result through a valid/ready handshake, so the pipeline control stalls while the unit is busy.
- Multiply uses radix-2 shift-add and divide uses restoring division; both run on magnitudes with a final sign fix and a fixed latency.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- ITER, 32, number of iteration cycles. Must equal XLEN.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request (state IDLE).
- op_i  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a_i  in  32  rs1 operand.
- b_i  in  32  rs2 operand.
- kill_i  in  1  pipeline flush; aborts the operation in flight.
- valid_o  out  1  one-cycle result strobe.
- result_o  out  32  result; held stable until the next accept.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; ready_o=1; valid_o=0.
  - result_o=0; all internal registers 0.
  - Reset asserted mid-operation discards the operation immediately and produces no valid_o.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - ready_o=1.
  - valid_i=1 at an edge means the request is accepted.
  - On accept, latch op_i, the operand signs, and |a|, |b| (signedness per op).
  - Clear the counter and accumulators; go to CALC.
- CALC (32 cycles):
  - One iteration per cycle; counter 0..31.
  - At count 31, go to FIX.
  - Multiply: 64-bit product register, shift-add on the unsigned magnitudes.
  - Divide: 32-bit quotient and 33-bit partial remainder, restoring subtract per bit, MSB first.
- FIX (1 cycle): apply sign fix and special cases, register result_o, go to DONE.
  - MUL: low 32 bits.
  - MULH / MULHSU / MULHU: high 32 bits of the signed×signed / signed×unsigned / unsigned×unsigned product.
  - Negate the 64-bit product when the operand signs differ (signed operands only).
  - Quotient is negated when the signs differ; remainder takes the sign of the dividend.
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a_i.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Special cases still take the full latency.
- DONE: valid_o=1 for exactly this cycle; ready_o=0; go to IDLE.
- Latency:
  - Accept edge ends cycle 0; valid_o is high in cycle 34.
  - Earliest next accept is in cycle 35, so throughput is 1 op per 35 cycles.
- ready_o is combinational from state only (ready_o = state==IDLE), with no dependency on valid_i.
- valid_i outside IDLE is ignored; operands are not re-sampled.
- kill_i:
  - In CALC or FIX: return to IDLE next edge; no valid_o; result_o keeps its previous value.
  - In DONE: valid_o is still produced.
  - In IDLE with valid_i: kill_i wins and the request is not accepted.
- Outputs are registered. Inputs need only be stable at the accept edge.

Test Plan:
- MUL: a=7, b=-3 (0xFFFFFFFD) -> result_o=0xFFFFFFEB, valid_o in cycle 34, ready_o low in cycles 1-34.
- MULH / MULHSU / MULHU with a=0x80000000, b=0xFFFFFFFF:
  - MULH -> 0x00000000
  - MULHSU -> 0x80000000
  - MULHU -> 0x7FFFFFFF
- DIV / REM: a=-7, b=2 -> DIV 0xFFFFFFFD (-3), REM 0xFFFFFFFF (-1); DIVU of the same operands -> 0x7FFFFFFC.
- Divide by zero: a=0x12345678, b=0 -> DIV and DIVU 0xFFFFFFFF; REM and REMU 0x12345678. Overflow: a=0x80000000, b=-1 -> DIV 0x80000000, REM 0.
- Abort cases:
  - kill_i in CALC cycle 10 -> no valid_o; ready_o=1 next cycle; result_o unchanged.
  - rst_ni pulsed low in cycle 20 -> immediate IDLE, result_o=0, no valid_o.
- Back-to-back requests: valid_i held high continuously -> accepts in cycles 0 and 35, valid_o in cycles 34 and 69. A valid_i change during CALC has no effect.
